// File: rtl/sonic_v1_15_pcs_eth_loopback_line_lb_rate_match_pkg.sv
// Shared XGMII word type, control codes and GAP/FRAME state for the
// line-loopback rate matcher and its FIFO.
package sonic_v1_15_pcs_eth_loopback_line_lb_rate_match_pkg;

  typedef logic [71:0] xgmii_word_t;

  localparam logic [7:0]  START_CODE = 8'hFB;
  localparam logic [7:0]  TERM_CODE  = 8'hFD;
  localparam xgmii_word_t IDLE_WORD  = {8'hFF, 64'h0707070707070707};
  localparam xgmii_word_t ERROR_WORD = {8'hFF, 64'hFEFEFEFEFEFEFEFE};

  typedef enum logic {
    GAP   = 1'b0,
    FRAME = 1'b1
  } lb_state_e;

  function automatic logic is_idle(input xgmii_word_t w);
    return w == IDLE_WORD;
  endfunction

  function automatic logic is_start(input xgmii_word_t w);
    return w[64] && (w[7:0] == START_CODE);
  endfunction

  // Terminate may sit in any lane, so every control-flagged byte is examined.
  function automatic logic is_term(input xgmii_word_t w);
    logic t;
    t = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (w[64+i] && (w[8*i +: 8] == TERM_CODE)) t = 1'b1;
    end
    return t;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
    return (en && (c != 16'hFFFF)) ? c + 16'd1 : c;
  endfunction

endpackage

// File: rtl/sonic_lb_sync_fifo.sv
// Single-clock FIFO with occupancy output; head word is visible
// combinationally on rd_data whenever the FIFO is not empty.
module sonic_lb_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 72
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic             push_ok, pop_ok;

  assign full    = (fill_q == (AW+1)'(DEPTH));
  assign empty   = (fill_q == '0);
  assign fill    = fill_q;
  assign rd_data = mem_q[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    fill_d   = fill_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  // NOTE: state flops use non-blocking assignments; combinational blocks above use blocking ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sonic_v1_15_pcs_eth_loopback_line_lb_rate_match.sv
// Line-loopback rate matcher: deletes inter-frame idles when the FIFO runs high,
// inserts idles while a frame start waits for LO_WM words of cushion.
// Statistics are built only when SONIC_LB_RM_STATS_EN is defined.
module sonic_v1_15_pcs_eth_loopback_line_lb_rate_match
  import sonic_v1_15_pcs_eth_loopback_line_lb_rate_match_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LO_WM = 4,
  parameter int HI_WM = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [71:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [71:0] out_data,
  output logic        stat_overflow,
  output logic        stat_underrun,
  output logic [15:0] stat_ins_cnt,
  output logic [15:0] stat_del_cnt
);

  localparam int FW = $clog2(DEPTH) + 1;
  localparam logic [FW-1:0] LO_LVL = FW'(LO_WM);
  localparam logic [FW-1:0] HI_LVL = FW'(HI_WM);

  logic [FW-1:0] fill;
  logic          full, empty, push, pop;
  xgmii_word_t   head;

  lb_state_e     in_state_q, in_state_d;
  lb_state_e     out_state_q, out_state_d;
  xgmii_word_t   out_data_q, out_data_d;
  logic          out_valid_q;
  logic          accept, del_evt, ovf_evt, ins_evt, und_evt;

  sonic_lb_sync_fifo #(.DEPTH(DEPTH), .WIDTH(72)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (head),
    .fill    (fill),
    .full    (full),
    .empty   (empty)
  );

  // out_valid_q doubles as "out of reset": input is held off until the first edge.
  assign in_ready  = out_valid_q & ~full;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    accept     = in_valid & in_ready;
    del_evt    = accept & is_idle(in_data) & (in_state_q == GAP) & (fill >= HI_LVL);
    push       = accept & ~del_evt;
    ovf_evt    = in_valid & full;
    in_state_d = in_state_q;
    if (accept) begin
      unique case (in_state_q)
        GAP:     if (is_start(in_data)) in_state_d = FRAME;
        FRAME:   if (is_term(in_data))  in_state_d = GAP;
        default: in_state_d = GAP;
      endcase
    end
  end

  always_comb begin
    out_state_d = out_state_q;
    out_data_d  = IDLE_WORD;
    pop         = 1'b0;
    ins_evt     = 1'b0;
    und_evt     = 1'b0;
    unique case (out_state_q)
      GAP: begin
        if (empty || (is_start(head) && (fill < LO_LVL))) begin
          ins_evt = 1'b1;
        end else begin
          pop        = 1'b1;
          out_data_d = head;
          if (is_start(head)) out_state_d = FRAME;
        end
      end
      FRAME: begin
        // Starved mid-frame: poison the frame rather than stall the adapter.
        if (empty) begin
          out_data_d = ERROR_WORD;
          und_evt    = 1'b1;
        end else begin
          pop        = 1'b1;
          out_data_d = head;
          if (is_term(head)) out_state_d = GAP;
        end
      end
      default: out_state_d = GAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_state_q  <= GAP;
      out_state_q <= GAP;
      out_data_q  <= IDLE_WORD;
      out_valid_q <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= 1'b1;
    end
  end

`ifdef SONIC_LB_RM_STATS_EN
  logic        ovf_q, ovf_d, und_q, und_d;
  logic [15:0] ins_q, ins_d, del_q, del_d;

  always_comb begin
    ovf_d = ovf_q | ovf_evt;
    und_d = und_q | und_evt;
    ins_d = sat_inc(ins_q, ins_evt);
    del_d = sat_inc(del_q, del_evt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      und_q <= 1'b0;
      ins_q <= '0;
      del_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      und_q <= und_d;
      ins_q <= ins_d;
      del_q <= del_d;
    end
  end

  assign stat_overflow = ovf_q;
  assign stat_underrun = und_q;
  assign stat_ins_cnt  = ins_q;
  assign stat_del_cnt  = del_q;
`else
  logic unused_stat_evts;
  assign unused_stat_evts = ^{ovf_evt, und_evt, ins_evt};

  assign stat_overflow = 1'b0;
  assign stat_underrun = 1'b0;
  assign stat_ins_cnt  = '0;
  assign stat_del_cnt  = '0;
`endif

endmodule

// File: tb/tb_sonic_v1_15_pcs_eth_loopback_line_lb_rate_match.sv
// Directed bench for the line-loopback rate matcher. A second instance with
// LO_WM above DEPTH never releases a frame, so the FIFO can be filled deliberately.
module tb_sonic_v1_15_pcs_eth_loopback_line_lb_rate_match;
  import sonic_v1_15_pcs_eth_loopback_line_lb_rate_match_pkg::*;

`ifdef SONIC_LB_RM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk, reset_n;
  logic        in_valid, in_ready, out_valid;
  logic [71:0] in_data, out_data;
  logic        stat_overflow, stat_underrun;
  logic [15:0] stat_ins_cnt, stat_del_cnt;

  logic        h_valid, h_ready, h_out_valid;
  logic [71:0] h_data, h_out_data;
  logic        h_overflow, h_underrun;
  logic [15:0] h_ins_cnt, h_del_cnt;

  int n_checks = 0;
  int n_errors = 0;

  xgmii_word_t in_q[$];
  logic        in_v_q[$];
  xgmii_word_t exp_q[$];

  sonic_v1_15_pcs_eth_loopback_line_lb_rate_match dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .stat_overflow (stat_overflow),
    .stat_underrun (stat_underrun),
    .stat_ins_cnt  (stat_ins_cnt),
    .stat_del_cnt  (stat_del_cnt)
  );

  sonic_v1_15_pcs_eth_loopback_line_lb_rate_match #(.DEPTH(16), .LO_WM(17), .HI_WM(12)) dut_hold (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (h_valid),
    .in_data       (h_data),
    .in_ready      (h_ready),
    .out_valid     (h_out_valid),
    .out_data      (h_out_data),
    .stat_overflow (h_overflow),
    .stat_underrun (h_underrun),
    .stat_ins_cnt  (h_ins_cnt),
    .stat_del_cnt  (h_del_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam xgmii_word_t START_W = {8'h01, 56'hD5555555555555, 8'hFB};
  localparam xgmii_word_t TERM_W  = {8'hFF, 64'h07070707070707FD};

  function automatic xgmii_word_t dword(input int i);
    return {8'h00, 64'h0101010101010101 * 64'(16 + i)};
  endfunction

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across two edges, releases it, then takes the first live edge.
  task automatic do_reset();
    in_valid = 1'b0; in_data = IDLE_WORD;
    h_valid  = 1'b0; h_data  = IDLE_WORD;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
  endtask

  task automatic add(input logic v, input xgmii_word_t d);
    in_v_q.push_back(v);
    in_q.push_back(d);
  endtask

  // Entry c of the input queues is sampled at edge c; exp_q[c] is out_data after it.
  task automatic run_stream(input string tag);
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c < in_q.size()) begin
        in_valid = in_v_q[c];
        in_data  = in_q[c];
      end else begin
        in_valid = 1'b0;
        in_data  = IDLE_WORD;
      end
      step();
      check($sformatf("%s_c%0d", tag, c), out_data, exp_q[c]);
    end
    in_valid = 1'b0;
    in_data  = IDLE_WORD;
    in_q.delete(); in_v_q.delete(); exp_q.delete();
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0; in_data = IDLE_WORD;
    h_valid  = 1'b0; h_data  = IDLE_WORD;

    // Reset values, then idle insertion from the first edge after release.
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, IDLE_WORD);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_ins_cnt", stat_ins_cnt, 16'd0);
    reset_n = 1'b1;
    step();
    check("first_out_valid", out_valid, 1'b1);
    check("first_out_data", out_data, IDLE_WORD);
    check("first_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("idle_%0d", i), out_data, IDLE_WORD);
    end
    check("idle_ins_cnt", stat_ins_cnt, STATS ? 16'd5 : 16'd0);

    // Full frame back-to-back: held until fill reaches LO_WM, then streamed.
    do_reset();
    add(1'b1, START_W);
    for (int i = 1; i <= 6; i++) add(1'b1, dword(i));
    add(1'b1, TERM_W);
    for (int c = 0; c < 4; c++) exp_q.push_back(IDLE_WORD);
    exp_q.push_back(START_W);
    for (int i = 1; i <= 6; i++) exp_q.push_back(dword(i));
    exp_q.push_back(TERM_W);
    exp_q.push_back(IDLE_WORD);
    exp_q.push_back(IDLE_WORD);
    run_stream("frame");
    check("frame_ins_cnt", stat_ins_cnt, STATS ? 16'd7 : 16'd0);
    check("frame_underrun", stat_underrun, 1'b0);

    // Six-cycle input gap mid-frame: three error words, then the frame resumes.
    do_reset();
    add(1'b1, START_W);
    for (int i = 1; i <= 3; i++) add(1'b1, dword(i));
    for (int i = 0; i < 6; i++) add(1'b0, dword(99));
    add(1'b1, dword(4));
    add(1'b1, dword(5));
    add(1'b1, TERM_W);
    for (int c = 0; c < 4; c++) exp_q.push_back(IDLE_WORD);
    exp_q.push_back(START_W);
    for (int i = 1; i <= 3; i++) exp_q.push_back(dword(i));
    for (int i = 0; i < 3; i++) exp_q.push_back(ERROR_WORD);
    exp_q.push_back(dword(4));
    exp_q.push_back(dword(5));
    exp_q.push_back(TERM_W);
    exp_q.push_back(IDLE_WORD);
    run_stream("gap");
    check("gap_underrun", stat_underrun, STATS);
    check("gap_ins_cnt", stat_ins_cnt, STATS ? 16'd6 : 16'd0);
    check("gap_overflow", stat_overflow, 1'b0);

    // Held instance: fill to 12, GAP idles deleted, in-frame idles kept, then overflow.
    do_reset();
    h_valid = 1'b1;
    h_data  = START_W; step();
    for (int i = 1; i <= 10; i++) begin h_data = dword(i); step(); end
    h_data = TERM_W; step();
    h_data = IDLE_WORD;
    repeat (3) step();
    check("hold_ready_at12", h_ready, 1'b1);
    check("hold_del_cnt", h_del_cnt, STATS ? 16'd3 : 16'd0);
    h_data = START_W; step();
    h_data = IDLE_WORD;
    repeat (2) step();
    check("hold_ready_at15", h_ready, 1'b1);
    step();
    check("hold_ready_full", h_ready, 1'b0);
    check("hold_del_kept", h_del_cnt, STATS ? 16'd3 : 16'd0);
    h_data = dword(50);
    repeat (3) step();
    check("ovf_ready", h_ready, 1'b0);
    check("ovf_flag", h_overflow, STATS);
    check("hold_out_idle", h_out_data, IDLE_WORD);
    check("hold_ins_cnt", h_ins_cnt, STATS ? 16'd23 : 16'd0);
    h_valid = 1'b0;

    // Asynchronous reset in the middle of a released frame.
    do_reset();
    in_valid = 1'b1;
    in_data  = START_W; step();
    for (int i = 1; i <= 5; i++) begin in_data = dword(i); step(); end
    check("midrst_in_frame", out_data, dword(1));
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, IDLE_WORD);
    check("midrst_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    in_data  = IDLE_WORD;
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("postrst_%0d", i), out_data, IDLE_WORD);
    end
    check("postrst_out_valid", out_valid, 1'b1);
    check("postrst_underrun", stat_underrun, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
